// File: rtl/validador_jugadas.sv
// Move validator for a two-player board game: checks each requested move, commits legal ones
// and counts fouls per player. Define TURNO_ESTRICTO_EN to enforce strict alternating turns.
module validador_jugadas #(
    parameter int unsigned CELDAS     = 9,
    parameter int unsigned MAX_FALTAS = 3,
    localparam int unsigned W         = $clog2(CELDAS),
    localparam int unsigned F         = $clog2(MAX_FALTAS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jugadaValida,
    input  logic [W-1:0]      jugadaCelda,
    input  logic              jugadaJugador,
    output logic              listo,
    output logic              aceptada,
    output logic              jugadaIlegal,
    output logic [2*CELDAS-1:0] tablero,
    output logic [F-1:0]      faltas1,
    output logic [F-1:0]      faltas2,
    output logic [1:0]        bloqueado,
    output logic              tableroLleno
);

    typedef enum logic [1:0] {ESPERA, VERIFICA, RESPUESTA, LLENO} estado_e;

    localparam logic [F-1:0] FaltasMax = F'(MAX_FALTAS);

    estado_e             estado_q, estado_d;
    logic [W-1:0]        celda_q, celda_d;
    logic                jugador_q, jugador_d;
    logic                acept_q, acept_d;
    logic                ilegal_q, ilegal_d;
    logic [2*CELDAS-1:0] tablero_q, tablero_d;
    logic [F-1:0]        faltas1_q, faltas1_d;
    logic [F-1:0]        faltas2_q, faltas2_d;
    logic                fuera, ocupada, es_ilegal, lleno;

`ifdef TURNO_ESTRICTO_EN
    logic turno_q, turno_d;
`endif

    // Verdict over the captured request; the index is range-checked before any cell lookup.
    always_comb begin
        fuera   = 32'(celda_q) >= CELDAS;
        ocupada = 1'b0;
        for (int unsigned i = 0; i < CELDAS; i++) begin
            if (32'(celda_q) == i) begin
                ocupada = tablero_q[2*i +: 2] != 2'b00;
            end
        end
        es_ilegal = fuera | ocupada | bloqueado[jugador_q];
`ifdef TURNO_ESTRICTO_EN
        es_ilegal = es_ilegal | (jugador_q != turno_q);
`endif
    end

    always_comb begin
        lleno = 1'b1;
        for (int unsigned i = 0; i < CELDAS; i++) begin
            lleno = lleno & (tablero_q[2*i +: 2] != 2'b00);
        end
    end

    always_comb begin
        estado_d  = estado_q;
        celda_d   = celda_q;
        jugador_d = jugador_q;
        acept_d   = 1'b0;
        ilegal_d  = 1'b0;
        tablero_d = tablero_q;
        faltas1_d = faltas1_q;
        faltas2_d = faltas2_q;
`ifdef TURNO_ESTRICTO_EN
        turno_d   = turno_q;
`endif
        case (estado_q)
            ESPERA: begin
                if (jugadaValida) begin
                    celda_d   = jugadaCelda;
                    jugador_d = jugadaJugador;
                    estado_d  = VERIFICA;
                end
            end
            VERIFICA: begin
                estado_d = RESPUESTA;
                if (es_ilegal) begin
                    ilegal_d = 1'b1;
                    if (jugador_q) begin
                        if (faltas2_q != FaltasMax) faltas2_d = faltas2_q + 1'b1;
                    end else begin
                        if (faltas1_q != FaltasMax) faltas1_d = faltas1_q + 1'b1;
                    end
                end else begin
                    acept_d = 1'b1;
                    for (int unsigned i = 0; i < CELDAS; i++) begin
                        if (32'(celda_q) == i) begin
                            tablero_d[2*i +: 2] = jugador_q ? 2'b10 : 2'b01;
                        end
                    end
`ifdef TURNO_ESTRICTO_EN
                    turno_d = ~turno_q;
`endif
                end
            end
            RESPUESTA: begin
                estado_d = lleno ? LLENO : ESPERA;
            end
            LLENO: begin
                estado_d = LLENO;
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= ESPERA;
            celda_q   <= '0;
            jugador_q <= 1'b0;
            acept_q   <= 1'b0;
            ilegal_q  <= 1'b0;
            tablero_q <= '0;
            faltas1_q <= '0;
            faltas2_q <= '0;
`ifdef TURNO_ESTRICTO_EN
            turno_q   <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            celda_q   <= celda_d;
            jugador_q <= jugador_d;
            acept_q   <= acept_d;
            ilegal_q  <= ilegal_d;
            tablero_q <= tablero_d;
            faltas1_q <= faltas1_d;
            faltas2_q <= faltas2_d;
`ifdef TURNO_ESTRICTO_EN
            turno_q   <= turno_d;
`endif
        end
    end

    assign listo        = estado_q == ESPERA;
    assign aceptada     = acept_q;
    assign jugadaIlegal = ilegal_q;
    assign tablero      = tablero_q;
    assign faltas1      = faltas1_q;
    assign faltas2      = faltas2_q;
    assign bloqueado    = {faltas2_q == FaltasMax, faltas1_q == FaltasMax};
    assign tableroLleno = lleno;

endmodule

// File: tb/tb_validador_jugadas.sv
// Directed bench for validador_jugadas (CELDAS=9, MAX_FALTAS=3): vector table plus
// hand-written sequences for lockout, full board, reset mid-move and first-turn rules.
module tb_validador_jugadas;

    logic        clk = 1'b0;
    logic        rst;
    logic        jugadaValida;
    logic [3:0]  jugadaCelda;
    logic        jugadaJugador;
    logic        listo, aceptada, jugadaIlegal, tableroLleno;
    logic [17:0] tablero;
    logic [1:0]  faltas1, faltas2, bloqueado;

    int checks = 0;
    int failures = 0;
    logic [17:0] modelo;

    validador_jugadas #(.CELDAS(9), .MAX_FALTAS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .jugadaValida (jugadaValida),
        .jugadaCelda  (jugadaCelda),
        .jugadaJugador(jugadaJugador),
        .listo        (listo),
        .aceptada     (aceptada),
        .jugadaIlegal (jugadaIlegal),
        .tablero      (tablero),
        .faltas1      (faltas1),
        .faltas2      (faltas2),
        .bloqueado    (bloqueado),
        .tableroLleno (tableroLleno)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       jug;
        logic [3:0] celda;
        logic       a;
        logic       il;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [1:0] bloq;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        jugadaValida = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelo = '0;
    endtask

    // Handshake, then sample the VERIFICA cycle and the RESPUESTA cycle at falling edges.
    task automatic mover(input logic j, input logic [3:0] c, output logic a, output logic il);
        int n;
        n = 0;
        a = 1'b0;
        il = 1'b0;
        while (!listo && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!listo) begin
            chk("listo_timeout", 64'(listo), 64'd1);
            return;
        end
        jugadaValida = 1'b1;
        jugadaJugador = j;
        jugadaCelda = c;
        @(negedge clk);
        jugadaValida = 1'b0;
        chk("verifica_sin_pulso", 64'({aceptada, jugadaIlegal}), 64'd0);
        @(negedge clk);
        a = aceptada;
        il = jugadaIlegal;
        chk("pulsos_exclusivos", 64'(a & il), 64'd0);
        @(negedge clk);
        chk("pulso_un_ciclo", 64'({aceptada, jugadaIlegal}), 64'd0);
    endtask

    initial begin
        logic a, il;

        vecs[0] = '{1'b0, 4'd4,  1'b1, 1'b0, 2'd0, 2'd0, 2'b00};
        vecs[1] = '{1'b1, 4'd4,  1'b0, 1'b1, 2'd0, 2'd1, 2'b00};
        vecs[2] = '{1'b1, 4'd0,  1'b1, 1'b0, 2'd0, 2'd1, 2'b00};
        vecs[3] = '{1'b0, 4'd9,  1'b0, 1'b1, 2'd1, 2'd1, 2'b00};
        vecs[4] = '{1'b0, 4'd15, 1'b0, 1'b1, 2'd2, 2'd1, 2'b00};
        vecs[5] = '{1'b0, 4'd9,  1'b0, 1'b1, 2'd3, 2'd1, 2'b01};
        vecs[6] = '{1'b0, 4'd1,  1'b0, 1'b1, 2'd3, 2'd1, 2'b01};

        rst = 1'b1;
        jugadaValida = 1'b0;
        jugadaCelda = '0;
        jugadaJugador = 1'b0;
        reset_dut();

        chk("reset_listo", 64'(listo), 64'd1);
        chk("reset_tablero", 64'(tablero), 64'd0);
        chk("reset_faltas", 64'({faltas1, faltas2}), 64'd0);
        chk("reset_pulsos", 64'({aceptada, jugadaIlegal}), 64'd0);
        chk("reset_bloq_lleno", 64'({bloqueado, tableroLleno}), 64'd0);

        for (int k = 0; k < 7; k++) begin
            mover(vecs[k].jug, vecs[k].celda, a, il);
            if (vecs[k].a) modelo[2*vecs[k].celda +: 2] = vecs[k].jug ? 2'b10 : 2'b01;
            chk($sformatf("v%0d_aceptada", k), 64'(a), 64'(vecs[k].a));
            chk($sformatf("v%0d_ilegal", k), 64'(il), 64'(vecs[k].il));
            chk($sformatf("v%0d_faltas1", k), 64'(faltas1), 64'(vecs[k].f1));
            chk($sformatf("v%0d_faltas2", k), 64'(faltas2), 64'(vecs[k].f2));
            chk($sformatf("v%0d_bloqueado", k), 64'(bloqueado), 64'(vecs[k].bloq));
            chk($sformatf("v%0d_tablero", k), 64'(tablero), 64'(modelo));
        end

        // Lock out jugador2 as well: requests keep being rejected, FSM keeps returning to ESPERA.
        for (int k = 0; k < 3; k++) mover(1'b1, 4'd4, a, il);
        chk("lock2_faltas2", 64'(faltas2), 64'd3);
        chk("lock2_bloqueado", 64'(bloqueado), 64'b11);
        mover(1'b1, 4'd2, a, il);
        chk("ambos_bloq_ilegal", 64'({a, il}), 64'b01);
        chk("ambos_bloq_listo", 64'(listo), 64'd1);
        chk("ambos_bloq_tablero", 64'(tablero), 64'(modelo));

        // Fill the board with alternating legal moves.
        reset_dut();
        for (int k = 0; k < 9; k++) begin
            if (k == 8) chk("casi_lleno", 64'(tableroLleno), 64'd0);
            mover(k[0], 4'(k), a, il);
            chk($sformatf("llenar%0d_aceptada", k), 64'({a, il}), 64'b10);
            modelo[2*k +: 2] = k[0] ? 2'b10 : 2'b01;
        end
        chk("lleno_flag", 64'(tableroLleno), 64'd1);
        chk("lleno_listo", 64'(listo), 64'd0);
        chk("lleno_tablero", 64'(tablero), 64'(modelo));
        jugadaValida = 1'b1;
        jugadaCelda = 4'd0;
        jugadaJugador = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lleno_ignora", 64'({aceptada, jugadaIlegal, listo}), 64'd0);
        end
        jugadaValida = 1'b0;
        chk("lleno_faltas", 64'({faltas1, faltas2}), 64'd0);

        // Reset while the move is in VERIFICA.
        reset_dut();
        jugadaValida = 1'b1;
        jugadaJugador = 1'b0;
        jugadaCelda = 4'd3;
        @(negedge clk);
        jugadaValida = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_verifica_pulsos", 64'({aceptada, jugadaIlegal}), 64'd0);
        chk("rst_verifica_tablero", 64'(tablero), 64'd0);
        chk("rst_verifica_listo", 64'(listo), 64'd1);
        @(negedge clk);
        chk("rst_verifica_despues", 64'({aceptada, jugadaIlegal, tablero}), 64'd0);

        // First move by jugador2.
        reset_dut();
        mover(1'b1, 4'd0, a, il);
`ifdef TURNO_ESTRICTO_EN
        chk("j2_primero_veredicto", 64'({a, il}), 64'b01);
        chk("j2_primero_faltas2", 64'(faltas2), 64'd1);
        chk("j2_primero_tablero", 64'(tablero), 64'd0);
`else
        chk("j2_primero_veredicto", 64'({a, il}), 64'b10);
        chk("j2_primero_faltas2", 64'(faltas2), 64'd0);
        chk("j2_primero_tablero", 64'(tablero), 64'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/validador_jugadas.md
VALIDADOR_JUGADAS -- requirements
Module: validador_jugadas

Interface
REQ-001 Parameter CELDAS, default 9: number of board cells, range 4..64.
REQ-002 Parameter MAX_FALTAS, default 3: illegal-move count at which a player is locked out, range 1..15.
REQ-003 The port list SHALL be as follows; W = clog2(CELDAS), F = clog2(MAX_FALTAS+1).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 jugadaValida  in  1  move request valid.
REQ-007 jugadaCelda  in  W  target cell index.
REQ-008 jugadaJugador  in  1  mover: 0 = jugador1, 1 = jugador2.
REQ-009 listo  out  1  ready; a request is taken on a clock edge where jugadaValida & listo.
REQ-010 aceptada  out  1  one-cycle pulse: legal move committed.
REQ-011 jugadaIlegal  out  1  one-cycle pulse: move rejected.
REQ-012 tablero  out  2*CELDAS  cell i at bits [2i+1:2i]; 00 empty, 01 jugador1, 10 jugador2; 11 never produced.
REQ-013 faltas1, faltas2  out  F  illegal-move counts per player.
REQ-014 bloqueado  out  2  bit0 jugador1 locked out, bit1 jugador2 locked out.
REQ-015 tableroLleno  out  1  high when every cell is non-empty.

Function
REQ-016 The FSM SHALL have exactly the states ESPERA, VERIFICA, RESPUESTA and LLENO.
REQ-017 listo SHALL be high only in ESPERA; the request fields SHALL be captured into internal registers on the handshake edge.
REQ-018 Transitions: ESPERA->VERIFICA on handshake; VERIFICA->RESPUESTA unconditionally; RESPUESTA->LLENO if every cell is occupied, else RESPUESTA->ESPERA; LLENO is left only by rst.
REQ-019 A move SHALL be illegal if any of these holds: the index is >= CELDAS; the target cell is not 00; the mover's bloqueado bit is set; or, when TURNO_ESTRICTO_EN is defined, the mover is not the player whose turn it is.
REQ-020 The verdict SHALL be computed in VERIFICA and registered so that aceptada or jugadaIlegal is high exactly during the RESPUESTA cycle, i.e. 2 cycles after the handshake edge.
REQ-021 aceptada and jugadaIlegal SHALL never be high together and SHALL be low outside RESPUESTA.
REQ-022 On a legal move, the target cell SHALL be written (01 or 10) on the same edge that raises aceptada; the cell is visible on tablero in the RESPUESTA cycle.
REQ-023 On an illegal move, tablero SHALL be unchanged and the mover's faltas counter SHALL increment on the same edge, saturating at MAX_FALTAS.
REQ-024 bloqueado[p] SHALL be high whenever faltas(p) == MAX_FALTAS, combinationally from the counter.
REQ-025 tableroLleno SHALL be the combinational AND over all cells of "cell != 00".
REQ-026 If both players are locked out, the FSM SHALL remain in ESPERA and reject every request as illegal; this is not a deadlock.
REQ-027 While listo is low, jugadaValida SHALL be ignored and no state SHALL change because of it.

Reset
REQ-028 rst high at a clock edge SHALL force: state ESPERA, tablero all 00, faltas1 = faltas2 = 0, aceptada = jugadaIlegal = 0, turn = jugador1.
REQ-029 rst SHALL take priority over every other event, including an in-flight move in VERIFICA or RESPUESTA, which is discarded with no pulse.
REQ-030 listo SHALL be high in the first cycle after rst is deasserted.

Configuration
REQ-031 Macro TURNO_ESTRICTO_EN defined: a turn register starts at jugador1 and toggles only on aceptada; a move from the other player is illegal and counts as a foul.
REQ-032 Macro TURNO_ESTRICTO_EN undefined: no turn register exists and either player may move at any time.

Verification
REQ-033 rst, then jugador1 requests cell 4 -> aceptada in cycle T+2; tablero[9:8] = 01; faltas unchanged.
REQ-034 jugador2 requests occupied cell 4 -> jugadaIlegal pulse; faltas2 = 1; tablero unchanged.
REQ-035 With MAX_FALTAS = 3, jugador1 makes three illegal requests (index 9, CELDAS = 9) -> faltas1 saturates at 3, bloqueado = 01; a fourth request to an empty cell -> jugadaIlegal.
REQ-036 Nine alternating legal moves fill the board -> tableroLleno = 1, state LLENO, listo stays 0; a further jugadaValida produces no pulse.
REQ-037 rst asserted during VERIFICA -> no pulse; tablero all 00; listo = 1 in the next cycle.
REQ-038 TURNO_ESTRICTO_EN defined: jugador2 moves first to empty cell 0 -> jugadaIlegal, faltas2 = 1; undefined: the same move -> aceptada.
